// File: rtl/mod_pipe_pkg.sv
// Shared types and constants for the modulation pipe segment stage.
// Holds the segment FSM state type, the segment word width and the index-width helper.
package mod_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seg_state_t;

    localparam int SEG_W     = 32;
    localparam int SEL_IDX_W = $clog2(SEG_W);

    // A single-segment build still needs a one-bit index port.
    function automatic int idx_width(input int num_seg);
        return (num_seg > 1) ? $clog2(num_seg) : 1;
    endfunction

endpackage

// File: rtl/seg_return_tracker.sv
// DP_LAT-deep {valid, index} delay line that tags each returning datapath result
// with the segment slot it belongs to; used only by the pipelined (SEG_PIPELINE_EN) build.
module seg_return_tracker #(
    parameter int DP_LAT = 1,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_go,
    input  logic [IDX_W-1:0] issue_idx,
    output logic             ret_vld,
    output logic [IDX_W-1:0] ret_idx
);

    logic             vld_pipe [DP_LAT];
    logic [IDX_W-1:0] idx_pipe [DP_LAT];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DP_LAT; i++) begin
                vld_pipe[i] <= 1'b0;
                idx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= issue_go;
            idx_pipe[0] <= issue_idx;
            for (int i = 1; i < DP_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    assign ret_vld = vld_pipe[DP_LAT-1];
    assign ret_idx = idx_pipe[DP_LAT-1];

endmodule

// File: rtl/mod_segment_sequencer.sv
// Schedules NUM_SEG per-segment branch evaluations onto one shared segment datapath.
// Define SEG_PIPELINE_EN for back-to-back issue; the default build issues one segment at a time.
module mod_segment_sequencer
    import mod_pipe_pkg::*;
#(
    parameter int  NUM_SEG = 8,
    parameter int  DP_LAT  = 1,
    localparam int IDX_W   = idx_width(NUM_SEG)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [31:0]              input_bit,
    input  logic [31:0]              zero,
    output logic                     dp_go,
    output logic                     dp_sel,
    output logic [IDX_W-1:0]         dp_idx,
    input  logic [31:0]              dp_result,
    output logic [NUM_SEG*SEG_W-1:0] segment_out,
    output logic                     valid,
    output logic                     busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SEG - 1);

    seg_state_t       state;
    logic [31:0]      sel_word;
    logic [IDX_W-1:0] seg_cnt;
    logic [IDX_W-1:0] next_cnt;

    assign next_cnt = seg_cnt + 1'b1;

`ifdef SEG_PIPELINE_EN
    logic             ret_vld;
    logic [IDX_W-1:0] ret_idx;

    seg_return_tracker #(
        .DP_LAT (DP_LAT),
        .IDX_W  (IDX_W)
    ) u_tracker (
        .clk       (clk),
        .reset     (reset),
        .issue_go  (dp_go),
        .issue_idx (dp_idx),
        .ret_vld   (ret_vld),
        .ret_idx   (ret_idx)
    );
`else
    localparam int LAT_W = $clog2(DP_LAT + 1);
    logic [LAT_W-1:0] wait_cnt;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            sel_word    <= '0;
            seg_cnt     <= '0;
            dp_go       <= 1'b0;
            dp_sel      <= 1'b0;
            dp_idx      <= '0;
            segment_out <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
`ifndef SEG_PIPELINE_EN
            wait_cnt    <= '0;
`endif
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sel_word <= input_bit ^ zero;
                        seg_cnt  <= '0;
                        dp_go    <= 1'b1;
                        dp_idx   <= '0;
                        dp_sel   <= input_bit[0] ^ zero[0];
                        busy     <= 1'b1;
                        state    <= ISSUE;
                    end else begin
                        state <= IDLE;
                    end
                end
`ifdef SEG_PIPELINE_EN
                // Issue and capture overlap: ISSUE also drains the datapath after the last issue.
                ISSUE: begin
                    if (dp_go) begin
                        if (seg_cnt == LAST_IDX) begin
                            dp_go <= 1'b0;
                        end else begin
                            seg_cnt <= next_cnt;
                            dp_idx  <= next_cnt;
                            dp_sel  <= sel_word[SEL_IDX_W'(next_cnt)];
                        end
                    end
                    if (ret_vld) begin
                        segment_out[int'(ret_idx)*SEG_W +: SEG_W] <= dp_result;
                        if (ret_idx == LAST_IDX) begin
                            valid <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
`else
                ISSUE: begin
                    dp_go    <= 1'b0;
                    wait_cnt <= LAT_W'(DP_LAT);
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == LAT_W'(1)) begin
                        segment_out[int'(seg_cnt)*SEG_W +: SEG_W] <= dp_result;
                        if (seg_cnt == LAST_IDX) begin
                            valid <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            seg_cnt <= next_cnt;
                            dp_go   <= 1'b1;
                            dp_idx  <= next_cnt;
                            dp_sel  <= sel_word[SEL_IDX_W'(next_cnt)];
                            state   <= ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mod_segment_sequencer.md
# mod_segment_sequencer

Controller for the modulation pipe's per-segment if/else stage. It accepts one 32-bit input word on a start strobe and schedules NUM_SEG segment evaluations onto a single shared segment datapath (the delay-based segment calculator). For each segment it selects either the `array_ref` branch or the `array_ref_m` branch from the latched word. It collects the results into a flat segment bus and reports completion through the pipe's common start/valid/busy handshake.

## Interface
- `NUM_SEG`, default 8: number of segments per word; range 1..32.
- `DP_LAT`, default 1: shared datapath latency in cycles from `dp_go` to a valid `dp_result`; must be ≥1.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `start` input 1: request to process `input_bit`; honoured only while `busy`=0.
- `input_bit` input 32: word; bit k selects the branch for segment k.
- `zero` input 32: branch polarity mask; segment k uses the `array_ref_m` branch when `input_bit[k]` ^ `zero[k]` = 1, otherwise `array_ref`.
- `dp_go` output 1: one-cycle issue strobe to the shared datapath.
- `dp_sel` output 1: branch select for the issued segment (1 = `array_ref_m`).
- `dp_idx` output $clog2(NUM_SEG) (min 1): index of the issued segment.
- `dp_result` input 32: datapath result, valid exactly DP_LAT cycles after the matching `dp_go`.
- `segment_out` output NUM_SEG*32: segment k occupies bits [32k+31:32k].
- `valid` output 1: one-cycle completion pulse.
- `busy` output 1: high while a word is in flight.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, DONE. WAIT is used in sequential mode only.
- **IDLE / DONE:**
  - `start`=1 latches `input_bit ^ zero` into `sel_word` and clears the segment counter.
  - The FSM then moves to ISSUE.
  - DONE otherwise returns to IDLE after one cycle.
- **ISSUE:** drives `dp_go`=1, `dp_idx`=k and `dp_sel`=`sel_word[k]`.
- **Sequential mode:**
  - ISSUE → WAIT, with a wait counter loaded to DP_LAT.
  - WAIT captures `dp_result` into segment k in its last cycle.
  - WAIT then moves to ISSUE (k+1), or to DONE after the last segment.
- **Result capture:** a captured result is written only into its own segment slot. All other slots hold their value.
- **Stale outputs:** `segment_out` keeps the previous word's values until each slot is overwritten. A new start does not clear it.
- **`start` while `busy`=1:** ignored, with no queueing. `input_bit` and `zero` are sampled only on the accepted start edge.
- **`dp_go`:** never asserted outside ISSUE.
- **Reset (any time, including mid-word):**
  - FSM → IDLE.
  - `dp_go`, `dp_sel`, `dp_idx`, `valid`, `busy` = 0.
  - `segment_out` = 0.
  - `sel_word` and all counters = 0.
  - Results arriving after reset deasserts are ignored.

## Timing
- **Cycle numbering:** cycle 0 = the cycle in which `start` is accepted.
- **Issue schedule (sequential mode):** segment k is issued in cycle 1+k·(DP_LAT+1). Its result is sampled at the end of cycle 1+k·(DP_LAT+1)+DP_LAT.
- **`busy`:** high from cycle 1 through the last capture cycle.
- **`valid`:** high for exactly one cycle, the cycle after the last capture, with `busy`=0 in that cycle.
- **Sequential latency:** `valid` in cycle NUM_SEG·(DP_LAT+1)+1. Defaults give cycle 17.
- **Back-to-back:** a `start` in the `valid` cycle is accepted; that cycle becomes cycle 0 of the next word.
- **Registered outputs:** all outputs are registered. There is no combinational path from `start` or `dp_result` to any output.

## Configuration
- **`SEG_PIPELINE_EN` defined:**
  - ISSUE stays for NUM_SEG consecutive cycles, one segment per cycle (k = 0..NUM_SEG-1 in cycles 1..NUM_SEG).
  - A DP_LAT-deep shift register of {valid, idx} routes each returning `dp_result` to its slot.
  - DONE follows the last capture. `valid` occurs in cycle NUM_SEG+DP_LAT+1 (defaults: cycle 10).
  - WAIT is unused.
- **`SEG_PIPELINE_EN` not defined:** sequential mode as above. Exactly one outstanding issue at any time.

## Structure
- **Shared package (`mod_pipe_pkg`):**
  - State enum type `seg_state_t` (IDLE, ISSUE, WAIT, DONE).
  - Constant SEG_W = 32.
  - Function computing the index width from NUM_SEG.
- **Sub-module `seg_return_tracker`:** the DP_LAT-deep valid/index shift register. It is instantiated only when `SEG_PIPELINE_EN` is defined.
- The FSM, counters and result registers stay in the top module.

## Test plan
- **Reset values:** assert `reset` low mid-run, then release → all outputs 0, FSM idle. A subsequent start completes normally.
- **Sequential run:** defaults, `input_bit`=32'h000000A5, `zero`=0; model returns idx·16+sel.
  - `dp_sel` sequence = 1,0,1,0,0,1,0,1.
  - Segment k = 16k + sel_k.
  - `valid` in cycle 17.
- **Polarity mask:** `input_bit`=32'hFF, `zero`=32'hFF → all `dp_sel`=0; `segment_out` matches the `array_ref`-branch values.
- **Start while busy:** `start` pulsed in cycles 3 and 9 → ignored, with a single `valid` pulse. Back-to-back start in the `valid` cycle → second word completes 17 cycles later.
- **Pipelined run:** `SEG_PIPELINE_EN` defined, DP_LAT=3, NUM_SEG=8.
  - `dp_go` high in cycles 1..8.
  - `valid` in cycle 12.
  - No slot is overwritten by a wrong index.
- **Edge parameters:** NUM_SEG=1, DP_LAT=1 → `valid` in cycle 3 (sequential) and cycle 3 (pipelined); `dp_idx` stays 0.
